// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I pipeline definitions: default widths, major opcode constants,
// ALUop encodings and the EX-stage control bundle used by id_ex_pipe.
// -----------------------------------------------------------------------------
package riscv_pkg;

    // Default datapath and register-index widths
    localparam int XLEN_DEF = 32;
    localparam int REGW_DEF = 5;

    // Major opcodes
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;

    // ALUop encodings driven by the control unit
    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } aluop_e;

    // Control signals carried from ID into EX
    typedef struct packed {
        logic [1:0] aluop;
        logic       alusrc;
        logic       mtor;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_CTRL_NOP = '0;

endpackage : riscv_pkg

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use hazard detector. Flags a hazard when the
// instruction in EX is a valid load to a non-zero register that the
// instruction in ID actually reads.
//
// Ports:
//   ex_valid, ex_memread, ex_rd   - state of the instruction currently in EX
//   id_valid, id_rs1, id_rs2      - instruction currently in ID
//   ALUsrc, memwrite              - ID control: decide whether rs2 is consumed
//   hazard                        - load-use hazard present this cycle
// -----------------------------------------------------------------------------
module hazard_detect #(
    parameter int REGW = 5
) (
    input  logic            ex_valid,
    input  logic            ex_memread,
    input  logic [REGW-1:0] ex_rd,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic            ALUsrc,
    input  logic            memwrite,
    output logic            hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = (id_rs1 == ex_rd);
    // rs2 is a real operand for register-register ops and for the store data;
    // an I-type instruction only has immediate bits in that field.
    assign rs2_hit = (id_rs2 == ex_rd) & (~ALUsrc | memwrite);

    assign hazard = ex_valid & ex_memread & (ex_rd != '0) & id_valid
                  & (rs1_hit | rs2_hit);

endmodule : hazard_detect

// File: rtl/id_ex_pipe.sv
// -----------------------------------------------------------------------------
// id_ex_pipe
// ID/EX pipeline register for the RV32I 5-stage pipeline. Captures decoded
// controls, operands, immediate and register indices each cycle, inserts a
// bubble on branch flush or load-use hazard, and requests a stall upstream.
//
// Build option:
//   LOAD_USE_STALL_EN - when defined, load-use hazards stall ID and insert a
//                       bubble; when undefined, stall is constantly 0.
//
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   id_valid, id_pc, id_*data    - ID instruction, PC and register read data
//   id_imm, id_rs1/rs2/rd        - immediate and register indices
//   id_funct                     - {funct7[5], funct3}
//   ALUop, ALUsrc, MtoR, regwrite,
//   memread, memwrite, branch    - control unit outputs
//   flush                        - taken branch resolved in EX
//   stall                        - load-use hold request to PC and IF/ID
//   ex_*                         - registered copies presented to EX
// -----------------------------------------------------------------------------
module id_ex_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int REGW = REGW_DEF
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1data,
    input  logic [XLEN-1:0] id_rs2data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic [3:0]      id_funct,
    input  logic [1:0]      ALUop,
    input  logic            ALUsrc,
    input  logic            MtoR,
    input  logic            regwrite,
    input  logic            memread,
    input  logic            memwrite,
    input  logic            branch,
    input  logic            flush,

    output logic            stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1data,
    output logic [XLEN-1:0] ex_rs2data,
    output logic [XLEN-1:0] ex_imm,
    output logic [REGW-1:0] ex_rs1,
    output logic [REGW-1:0] ex_rs2,
    output logic [REGW-1:0] ex_rd,
    output logic [3:0]      ex_funct,
    output logic [1:0]      ex_ALUop,
    output logic            ex_ALUsrc,
    output logic            ex_MtoR,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_branch
);

`ifdef LOAD_USE_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic     hazard_raw;
    logic     hazard;
    logic     insert_bubble;
    ex_ctrl_t id_ctrl;
    ex_ctrl_t ex_ctrl;

    hazard_detect #(
        .REGW (REGW)
    ) u_hazard_detect (
        .ex_valid   (ex_valid),
        .ex_memread (ex_ctrl.memread),
        .ex_rd      (ex_rd),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .ALUsrc     (ALUsrc),
        .memwrite   (memwrite),
        .hazard     (hazard_raw)
    );

    // With the stall disabled the detector is gated off and trims away.
    assign hazard = hazard_raw & STALL_EN;

    // A flush kills the ID instruction itself, so holding it would be pointless.
    assign stall = hazard & ~flush;

    assign insert_bubble = flush | hazard;

    // Branches come out of the control unit with regwrite=1; writes to x0 and
    // invalid slots are dropped here so EX/MEM/WB never see them.
    always_comb begin
        id_ctrl          = EX_CTRL_NOP;
        id_ctrl.aluop    = ALUop;
        id_ctrl.alusrc   = ALUsrc;
        id_ctrl.mtor     = MtoR;
        id_ctrl.regwrite = regwrite & id_valid & (id_rd != '0) & ~branch;
        id_ctrl.memread  = memread;
        id_ctrl.memwrite = memwrite;
        id_ctrl.branch   = branch;
    end

    // NOTE: every pipeline state bit uses non-blocking assignment so all fields
    // update together on the edge and the hazard logic sees the old EX state.
    always_ff @(posedge clk) begin
        // Reset, flush and hazard all leave a clean bubble: data and indices
        // are cleared too so nothing stale can alias a later forwarding match.
        if (rst || insert_bubble) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_rs1data <= '0;
            ex_rs2data <= '0;
            ex_imm     <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_rd      <= '0;
            ex_funct   <= '0;
            ex_ctrl    <= EX_CTRL_NOP;
        end else begin
            ex_valid   <= id_valid;
            ex_pc      <= id_pc;
            ex_rs1data <= id_rs1data;
            ex_rs2data <= id_rs2data;
            ex_imm     <= id_imm;
            ex_rs1     <= id_rs1;
            ex_rs2     <= id_rs2;
            ex_rd      <= id_rd;
            ex_funct   <= id_funct;
            ex_ctrl    <= id_ctrl;
        end
    end

    assign ex_ALUop    = ex_ctrl.aluop;
    assign ex_ALUsrc   = ex_ctrl.alusrc;
    assign ex_MtoR     = ex_ctrl.mtor;
    assign ex_regwrite = ex_ctrl.regwrite;
    assign ex_memread  = ex_ctrl.memread;
    assign ex_memwrite = ex_ctrl.memwrite;
    assign ex_branch   = ex_ctrl.branch;

endmodule : id_ex_pipe

// File: tb/tb_id_ex_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_ex_pipe
// Directed scoreboard bench for id_ex_pipe. The driver pushes the expected
// stall for the current cycle and the expected EX contents after the next
// edge; two monitor processes pop and compare. Expectations follow the
// LOAD_USE_STALL_EN build option the RTL is compiled with.
// -----------------------------------------------------------------------------
module tb_id_ex_pipe;

`ifdef LOAD_USE_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1data;
        logic [31:0] rs2data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  funct;
        logic [1:0]  aluop;
        logic        alusrc;
        logic        mtor;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        branch;
    } slot_t;

    typedef struct {
        string name;
        slot_t exp;
    } ex_exp_t;

    typedef struct {
        string name;
        bit    chk;
        bit    exp;
    } stall_exp_t;

    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic        rst, flush;
    slot_t       din;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1data, ex_rs2data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_funct;
    logic [1:0]  ex_ALUop;
    logic        ex_ALUsrc, ex_MtoR, ex_regwrite, ex_memread, ex_memwrite, ex_branch;

    ex_exp_t    ex_q[$];
    stall_exp_t stall_q[$];
    int         errors = 0;
    int         checks = 0;

    id_ex_pipe #(.XLEN(32), .REGW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (din.valid),
        .id_pc       (din.pc),
        .id_rs1data  (din.rs1data),
        .id_rs2data  (din.rs2data),
        .id_imm      (din.imm),
        .id_rs1      (din.rs1),
        .id_rs2      (din.rs2),
        .id_rd       (din.rd),
        .id_funct    (din.funct),
        .ALUop       (din.aluop),
        .ALUsrc      (din.alusrc),
        .MtoR        (din.mtor),
        .regwrite    (din.regwrite),
        .memread     (din.memread),
        .memwrite    (din.memwrite),
        .branch      (din.branch),
        .flush       (flush),
        .stall       (stall),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .ex_rs1data  (ex_rs1data),
        .ex_rs2data  (ex_rs2data),
        .ex_imm      (ex_imm),
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .ex_rd       (ex_rd),
        .ex_funct    (ex_funct),
        .ex_ALUop    (ex_ALUop),
        .ex_ALUsrc   (ex_ALUsrc),
        .ex_MtoR     (ex_MtoR),
        .ex_regwrite (ex_regwrite),
        .ex_memread  (ex_memread),
        .ex_memwrite (ex_memwrite),
        .ex_branch   (ex_branch)
    );

    // ---------------- instruction builders ----------------
    function automatic slot_t r_op(input logic [31:0] pc, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [3:0] funct,
                                   input logic [31:0] d1, input logic [31:0] d2);
        slot_t s = '0;
        s.valid = 1'b1; s.pc = pc; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
        s.funct = funct; s.rs1data = d1; s.rs2data = d2;
        s.aluop = 2'b10; s.regwrite = 1'b1;
        return s;
    endfunction

    function automatic slot_t lw_op(input logic [31:0] pc, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [31:0] imm);
        slot_t s = '0;
        s.valid = 1'b1; s.pc = pc; s.rd = rd; s.rs1 = rs1; s.imm = imm;
        s.funct = 4'b0010; s.rs1data = 32'h0000_1000;
        s.aluop = 2'b00; s.alusrc = 1'b1; s.mtor = 1'b1;
        s.regwrite = 1'b1; s.memread = 1'b1;
        return s;
    endfunction

    function automatic slot_t sw_op(input logic [31:0] pc, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic [31:0] imm);
        slot_t s = '0;
        s.valid = 1'b1; s.pc = pc; s.rs1 = rs1; s.rs2 = rs2; s.imm = imm;
        s.rd = imm[4:0]; s.funct = 4'b0010; s.rs1data = 32'h0000_2000;
        s.rs2data = 32'hDEAD_BEEF;
        s.aluop = 2'b00; s.alusrc = 1'b1; s.memwrite = 1'b1;
        return s;
    endfunction

    function automatic slot_t addi_op(input logic [31:0] pc, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2_field,
                                      input logic [31:0] imm);
        slot_t s = '0;
        s.valid = 1'b1; s.pc = pc; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2_field;
        s.imm = imm; s.rs1data = 32'h0000_0011;
        s.aluop = 2'b11; s.alusrc = 1'b1; s.regwrite = 1'b1;
        return s;
    endfunction

    function automatic slot_t beq_op(input logic [31:0] pc, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [31:0] imm);
        slot_t s = '0;
        s.valid = 1'b1; s.pc = pc; s.rs1 = rs1; s.rs2 = rs2; s.imm = imm;
        s.rd = 5'd4; s.rs1data = 32'd9; s.rs2data = 32'd9;
        s.aluop = 2'b01; s.branch = 1'b1; s.regwrite = 1'b1;
        return s;
    endfunction

    function automatic slot_t rnd_slot();
        slot_t s;
        s = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return s;
    endfunction

    // Expected EX contents after a normal load: a plain copy, with the write
    // enable dropped for invalid slots, x0 destinations and branches.
    function automatic slot_t passed(input slot_t v);
        slot_t e = v;
        e.regwrite = v.regwrite & v.valid & (v.rd != 5'd0) & ~v.branch;
        return e;
    endfunction

    localparam slot_t BUBBLE = '0;

    // ---------------- driver ----------------
    task automatic cycle(input string name, input slot_t v, input bit f, input bit r,
                         input bit chk_stall, input bit exp_stall, input slot_t exp);
        stall_exp_t se;
        ex_exp_t    ee;
        din   = v;
        flush = f;
        rst   = r;
        se.name = name; se.chk = chk_stall; se.exp = exp_stall;
        ee.name = name; ee.exp = exp;
        stall_q.push_back(se);
        ex_q.push_back(ee);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string name, input slot_t v);
        cycle(name, v, 1'b0, 1'b0, 1'b1, 1'b0, passed(v));
    endtask

    // Instruction that depends on the load now in EX: with stalling enabled,
    // one stall cycle and a bubble, then upstream re-presents it.
    task automatic issue_dep(input string name, input slot_t v);
        if (STALL_EN) begin
            cycle({name, "_stall"}, v, 1'b0, 1'b0, 1'b1, 1'b1, BUBBLE);
            cycle({name, "_retry"}, v, 1'b0, 1'b0, 1'b1, 1'b0, passed(v));
        end else begin
            issue(name, v);
        end
    endtask

    // ---------------- monitors ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (stall_q.size() > 0) begin
                stall_exp_t se;
                se = stall_q.pop_front();
                if (se.chk) begin
                    checks++;
                    if (stall !== se.exp) begin
                        errors++;
                        $display("FAIL %s stall: got %0b expected %0b", se.name, stall, se.exp);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (ex_q.size() > 0) begin
                ex_exp_t ee;
                slot_t   act;
                ee = ex_q.pop_front();
                act = {ex_valid, ex_pc, ex_rs1data, ex_rs2data, ex_imm, ex_rs1, ex_rs2,
                       ex_rd, ex_funct, ex_ALUop, ex_ALUsrc, ex_MtoR, ex_regwrite,
                       ex_memread, ex_memwrite, ex_branch};
                checks++;
                if (act !== ee.exp) begin
                    errors++;
                    $display("FAIL %s ex: got %p expected %p", ee.name, act, ee.exp);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        slot_t add_a, lw5, add_dep, sub_b2b, st, addi_nu, beq_b, lw0, add_x0, idle;

        // Reset with random inputs; stall undefined before the first edge
        cycle("reset0", rnd_slot(), 1'($urandom), 1'b1, 1'b0, 1'b0, BUBBLE);
        cycle("reset1", rnd_slot(), 1'($urandom), 1'b1, 1'b1, 1'b0, BUBBLE);

        // add x3,x1,x2 with operands 5 and 7
        add_a = r_op(32'h100, 5'd3, 5'd1, 5'd2, 4'b0000, 32'd5, 32'd7);
        issue("add_pass", add_a);

        // lw x5,0(x1); add x6,x5,x2; sub x7,x5,x6 (only the first stalls)
        lw5     = lw_op(32'h104, 5'd5, 5'd1, 32'd0);
        add_dep = r_op(32'h108, 5'd6, 5'd5, 5'd2, 4'b0000, 32'd40, 32'd2);
        sub_b2b = r_op(32'h10C, 5'd7, 5'd5, 5'd6, 4'b1000, 32'd40, 32'd42);
        issue("lw_a", lw5);
        issue_dep("add_loaduse", add_dep);
        issue("sub_b2b", sub_b2b);

        // lw x5; sw x5,0(x1): store data is a real rs2 use
        issue("lw_b", lw5);
        st = sw_op(32'h110, 5'd1, 5'd5, 32'd0);
        issue_dep("sw_rs2_use", st);

        // lw x5; addi x7,x1,4 with rs2 field = 5: immediate, no use
        issue("lw_c", lw5);
        addi_nu = addi_op(32'h114, 5'd7, 5'd1, 5'd5, 32'd4);
        issue("addi_no_use", addi_nu);

        // lw x5; add x6,x5,x2 together with flush: bubble, no stall
        issue("lw_d", lw5);
        cycle("flush_hazard", add_dep, 1'b1, 1'b0, 1'b1, 1'b0, BUBBLE);

        // beq with regwrite=1 from control: ex_regwrite must be 0
        beq_b = beq_op(32'h118, 5'd1, 5'd2, 32'h0000_0010);
        issue("beq_sanitise", beq_b);

        // lw x0; add x6,x0,x0: x0 never creates a hazard or a write
        lw0    = lw_op(32'h11C, 5'd0, 5'd1, 32'd8);
        add_x0 = r_op(32'h120, 5'd6, 5'd0, 5'd0, 4'b0000, 32'd0, 32'd0);
        issue("lw_x0", lw0);
        issue("add_x0", add_x0);

        // rst during a stall: stall may show this cycle, next edge clears all
        issue("lw_e", lw5);
        cycle("rst_mid_stall", add_dep, 1'b0, 1'b1, 1'b1, STALL_EN, BUBBLE);
        issue("after_rst", add_dep);

        // Idle slot drains the pipe
        idle = '0;
        issue("idle", idle);
        issue("idle2", idle);

        #5;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_id_ex_pipe
